// File: rtl/clock_monitor.sv
// Period / in-range / stall monitor for a slow clock sampled as async data on i_clk.
// Optional high-time measurement: define CLOCK_MONITOR_DUTY_EN.
module clock_monitor #(
  parameter int DEFAULT_CLK = 100000000,
  parameter int FREQ        = 1,
  parameter int TOL         = 0,
  parameter int CNT_W       = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_mon,
  output logic             o_tick,
  output logic [CNT_W-1:0] o_period,
  output logic [CNT_W-1:0] o_high,
  output logic             o_valid,
  output logic             o_in_range,
  output logic             o_timeout
);

  localparam logic [CNT_W:0] EXP  = (CNT_W+1)'(DEFAULT_CLK / FREQ);
  localparam logic [CNT_W:0] LIM  = EXP << 1;
  localparam logic [CNT_W:0] TOLW = (CNT_W+1)'(TOL);
  localparam logic [CNT_W:0] LO   = (EXP > TOLW) ? EXP - TOLW : '0;
  localparam logic [CNT_W:0] HI   = EXP + TOLW;

  typedef enum logic [1:0] {IDLE, MEASURE, TIMEOUT} state_t;

  state_t           state_q, state_d;
  logic             s1, s, s_d, rise;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W:0]   cnt_inc;
  logic             hit_lim, latch, to_set, to_clr;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      s1  <= 1'b0;
      s   <= 1'b0;
      s_d <= 1'b0;
    end else begin
      s1  <= i_mon;
      s   <= s1;
      s_d <= s;
    end
  end

  assign rise    = s & ~s_d;
  assign cnt_inc = {1'b0, cnt} + (CNT_W+1)'(1);
  assign hit_lim = (cnt_inc == LIM);

  // saturates at 2*EXP so a stalled input never wraps back into range
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst)                cnt <= '0;
    else if (rise)             cnt <= '0;
    else if ({1'b0, cnt} != LIM) cnt <= cnt_inc[CNT_W-1:0];
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    latch   = 1'b0;
    to_set  = 1'b0;
    to_clr  = 1'b0;
    case (state_q)
      IDLE:    if (rise) state_d = MEASURE;
      MEASURE: begin
        if (rise) latch = 1'b1;
        else if (hit_lim) begin
          state_d = TIMEOUT;
          to_set  = 1'b1;
        end
      end
      TIMEOUT: if (rise) begin
        state_d = MEASURE;
        to_clr  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      o_tick     <= 1'b0;
      o_valid    <= 1'b0;
      o_period   <= '0;
      o_in_range <= 1'b0;
      o_timeout  <= 1'b0;
    end else begin
      o_tick  <= rise;
      o_valid <= latch;
      if (latch) begin
        o_period   <= cnt_inc[CNT_W-1:0];
        o_in_range <= (cnt_inc >= LO) && (cnt_inc <= HI);
      end
      if (to_set) begin
        o_timeout  <= 1'b1;
        o_in_range <= 1'b0;
      end
      if (to_clr) o_timeout <= 1'b0;
    end
  end

`ifdef CLOCK_MONITOR_DUTY_EN
  logic [CNT_W-1:0] hcnt;
  logic [CNT_W:0]   hcnt_inc;

  assign hcnt_inc = {1'b0, hcnt} + (CNT_W+1)'(1);

  // counts only while s is high, so it stops by itself on the falling edge
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst)                          hcnt <= '0;
    else if (rise)                       hcnt <= '0;
    else if (s && ({1'b0, hcnt} != LIM)) hcnt <= hcnt_inc[CNT_W-1:0];
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst)     o_high <= '0;
    else if (latch) o_high <= hcnt_inc[CNT_W-1:0];
  end
`else
  assign o_high = '0;
`endif

endmodule

// File: tb/tb_clock_monitor.sv
// Directed bench for clock_monitor: EXP=20, one DUT with TOL=0 and one with TOL=2.
module tb_clock_monitor;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          rst_n, mon;
  logic          tick, valid, in_rng, tmo;
  logic [CW-1:0] period, high;
  logic          tick2, valid2, in_rng2, tmo2;
  logic [CW-1:0] period2, high2;

  int n_cmp = 0, n_err = 0;
  int cyc = 0, n_valid = 0, n_tmo = 0, last_tick = 0, tmo_delta = -1;
  logic tmo_prev = 1'b0, valid_prev = 1'b0;
  int n_b2b = 0;
  int v0, t0;

`ifdef CLOCK_MONITOR_DUTY_EN
  localparam bit DUTY = 1'b1;
`else
  localparam bit DUTY = 1'b0;
`endif

  always #5 clk = ~clk;

  clock_monitor #(.DEFAULT_CLK(20), .FREQ(1), .TOL(0), .CNT_W(CW)) dut (
    .i_clk(clk), .i_rst(rst_n), .i_mon(mon), .o_tick(tick), .o_period(period),
    .o_high(high), .o_valid(valid), .o_in_range(in_rng), .o_timeout(tmo));

  clock_monitor #(.DEFAULT_CLK(20), .FREQ(1), .TOL(2), .CNT_W(CW)) dut2 (
    .i_clk(clk), .i_rst(rst_n), .i_mon(mon), .o_tick(tick2), .o_period(period2),
    .o_high(high2), .o_valid(valid2), .o_in_range(in_rng2), .o_timeout(tmo2));

  always @(posedge clk) cyc <= cyc + 1;

  // observe pulses away from the active edge
  always @(negedge clk) begin
    if (valid) n_valid++;
    if (valid && valid_prev) n_b2b++;
    if (tick) last_tick = cyc;
    if (tmo && !tmo_prev) begin
      n_tmo++;
      tmo_delta = cyc - last_tick;
    end
    tmo_prev   = tmo;
    valid_prev = valid;
  end

  task automatic chk(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic drive(input logic lvl, input int n);
    mon = lvl;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    mon   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_period", period, 0);
    chk("rst_flags", {28'd0, tick, valid, in_rng, tmo}, 0);
    chk("rst_high", high, 0);
    rst_n = 1'b1;
    drive(0, 4);

    // ideal divider, N=10
    drive(1, 10);
    chk("first_edge_no_valid", n_valid, 0);
    drive(0, 10); drive(1, 10);
    chk("p20_valid", n_valid, 1);
    chk("p20_period", period, 20);
    chk("p20_in_range", in_rng, 1);
    chk("p20_high", high, DUTY ? 10 : 0);
    drive(0, 10); drive(1, 10);
    chk("p20_valid2", n_valid, 2);
    chk("p20_period2", period, 20);

    // N=11: first period mixes 10 high + 11 low
    drive(0, 11); drive(1, 11);
    chk("p21_period", period, 21);
    chk("p21_range_tol0", in_rng, 0);
    chk("p21_range_tol2", in_rng2, 1);
    drive(0, 11); drive(1, 11);
    chk("p22_period", period, 22);
    chk("p22_range_tol0", in_rng, 0);
    chk("p22_range_tol2", in_rng2, 1);
    chk("p22_high", high, DUTY ? 11 : 0);

    // stall
    drive(0, 50);
    chk("tmo_level", tmo, 1);
    chk("tmo_delta", tmo_delta, 40);
    chk("tmo_in_range", in_rng, 0);
    chk("tmo_period_hold", period, 22);
    v0 = n_valid;
    drive(1, 10);
    chk("tmo_cleared", tmo, 0);
    chk("tmo_resume_no_valid", n_valid, v0);
    drive(0, 10); drive(1, 10);
    chk("tmo_resume_valid", n_valid, v0 + 1);
    chk("tmo_resume_period", period, 20);

    // edge exactly on the 2*EXP threshold
    t0 = n_tmo;
    drive(0, 30); drive(1, 10);
    chk("lim_period", period, 40);
    chk("lim_no_timeout", n_tmo, t0);
    chk("lim_tmo_level", tmo, 0);
    chk("lim_in_range", in_rng, 0);

    // reset mid-period
    drive(0, 5);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_period", period, 0);
    chk("mid_rst_flags", {28'd0, tick, valid, in_rng, tmo}, 0);
    chk("mid_rst_high", high, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    v0 = n_valid;
    drive(0, 3); drive(1, 10);
    chk("post_rst_first_edge", n_valid, v0);
    drive(0, 10); drive(1, 10);
    chk("post_rst_valid", n_valid, v0 + 1);
    chk("post_rst_period", period, 20);

    // duty: 5 high / 15 low
    drive(0, 15); drive(1, 5); drive(0, 15); drive(1, 5);
    chk("duty_period", period, 20);
    chk("duty_high", high, DUTY ? 5 : 0);
    chk("duty_in_range", in_rng, 1);
    drive(0, 5);

    chk("no_b2b_valid", n_b2b, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
